// File: rtl/sevseg_pkg.sv
// sevseg_pkg: shared constants and the hex-to-segment table for the seven-segment scan driver.
// All segment, anode and decimal-point values are active low.
package sevseg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic       AN_ON     = 1'b0;
   localparam logic       AN_OFF    = 1'b1;
   localparam logic       DP_ON     = 1'b0;
   localparam logic       DP_OFF    = 1'b1;

   // Bit order {a,b,c,d,e,f,g}; entry index is the hex value.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
      return HEX_SEG[hex];
   endfunction

endpackage

// File: rtl/sevdecoder.sv
// sevdecoder: combinational hex nibble to active-low seven-segment pattern.
module sevdecoder
   import sevseg_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   assign seg_o = hex_to_seg(hex_i);

endmodule

// File: rtl/sevseg_scan_driver.sv
// sevseg_scan_driver: multiplexed seven-segment driver with guard interval, blink and
// leading-zero suppression; each slot shows a snapshot taken at its first cycle.
module sevseg_scan_driver
   import sevseg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 100000,
   parameter int GUARD      = 1000,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic [NUM_DIGITS-1:0]   blink_in,
   input  logic                    lz_blank,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    slot_tick
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
   logic                  blink_phase_q, blink_phase_d;
   logic [3:0]            snap_nib_q, snap_nib_d;
   logic                  snap_dp_q, snap_dp_d;
   logic                  snap_blank_q, snap_blank_d;
   logic                  snap_blink_q, snap_blink_d;
   logic                  snap_lz_q, snap_lz_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  tick_q, tick_d;

   logic [3:0]            nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] lz_sup;
   logic                  lz_run;
   logic                  wrap, blink_wrap, load, guard, dark;
   logic [6:0]            dec_seg;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
      assign nib[g] = digits_in[4*g +: 4];
   end

   // Walk down from the most significant digit; suppression stops at the first nonzero nibble.
   always_comb begin
      lz_sup = '0;
      lz_run = lz_blank;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         lz_run    = lz_run && (nib[i] == 4'h0);
         lz_sup[i] = lz_run;
      end
   end

   sevdecoder u_dec (
      .hex_i (snap_nib_q),
      .seg_o (dec_seg)
   );

   always_comb begin
      wrap          = cnt_q == CW'(SCAN_DIV - 1);
      blink_wrap    = blink_cnt_q == BW'(BLINK_DIV - 1);
      load          = cnt_q == '0;
      guard         = cnt_q < CW'(GUARD);
      dark          = snap_blank_q || snap_lz_q || (snap_blink_q && !blink_phase_q);
      cnt_d         = wrap ? '0 : cnt_q + 1'b1;
      idx_d         = !wrap ? idx_q : (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
      blink_phase_d = blink_phase_q ^ blink_wrap;
      snap_nib_d    = load ? nib[idx_q]      : snap_nib_q;
      snap_dp_d     = load ? dp_in[idx_q]    : snap_dp_q;
      snap_blank_d  = load ? blank_in[idx_q] : snap_blank_q;
      snap_blink_d  = load ? blink_in[idx_q] : snap_blink_q;
      snap_lz_d     = load ? lz_sup[idx_q]   : snap_lz_q;
      seg_d         = (guard || dark) ? SEG_BLANK : dec_seg;
      dp_d          = (guard || dark || !snap_dp_q) ? DP_OFF : DP_ON;
      an_d          = {NUM_DIGITS{AN_OFF}};
      if (!guard) an_d[idx_q] = AN_ON;
      tick_d        = wrap;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
         snap_nib_q    <= '0;
         snap_dp_q     <= 1'b0;
         snap_blank_q  <= 1'b0;
         snap_blink_q  <= 1'b0;
         snap_lz_q     <= 1'b0;
         seg_q         <= SEG_BLANK;
         dp_q          <= DP_OFF;
         an_q          <= {NUM_DIGITS{AN_OFF}};
         tick_q        <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         snap_nib_q    <= snap_nib_d;
         snap_dp_q     <= snap_dp_d;
         snap_blank_q  <= snap_blank_d;
         snap_blink_q  <= snap_blink_d;
         snap_lz_q     <= snap_lz_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         an_q          <= an_d;
         tick_q        <= tick_d;
      end
   end

   assign seg_out   = seg_q;
   assign dp_out    = dp_q;
   assign an_out    = an_q;
   assign slot_tick = tick_q;

endmodule
